// File: rtl/eth_pll_seq_pkg.sv
// Shared definitions for the Ethernet PLL reset sequencer.
// The state encoding is visible on seq_state, so the values are fixed.
package eth_pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        REL_PHY   = 3'd3,
        REL_MAC   = 3'd4,
        RUN       = 3'd5
    } seq_state_e;

    localparam int RETRY_W    = 4;
    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/eth_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Asynchronous active-high reset clears both stages to 0.
module eth_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the pre-edge
            // values, giving a real two-stage pipeline rather than one wire.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/eth_pll_reset_sequencer.sv
// Ethernet PLL reset sequencer: pulses the PLL reset, waits for a stable
// lock, then releases the PHY and MAC resets in order. Any lock loss after
// release restarts the whole sequence. Everything runs on refclk.
// Optional build macro ETH_PLL_LOCK_LOSS_CNT_EN adds the lock_loss_cnt output.
module eth_pll_reset_sequencer
    import eth_pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int SEQ_GAP_CYCLES      = 256,
    parameter int CNT_W               = 20
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               phy_rst,
    output logic               mac_rst,
    output logic               sys_ready,
    output logic [2:0]         seq_state,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    seq_state_e       state;
    seq_state_e       next_state;
    logic [CNT_W-1:0] timer;
    logic             lock_s;
    logic             timeout_hit;
    logic             lock_lost;

    eth_bit_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign seq_state = state;

    // Next-state decode; lock is checked before timeout so a coincident lock wins.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        next_state  = state;
        timeout_hit = 1'b0;
        lock_lost   = 1'b0;
        case (state)
            PLL_RST: begin
                if (timer == CNT_W'(PLL_RST_CYCLES - 1)) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (timer == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    next_state  = PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) next_state = WAIT_LOCK;
                else if (timer == CNT_W'(STABLE_CYCLES - 1)) next_state = REL_PHY;
            end
            REL_PHY: begin
                if (!lock_s) begin
                    next_state = PLL_RST;
                    lock_lost  = 1'b1;
                end else if (timer == CNT_W'(SEQ_GAP_CYCLES - 1)) begin
                    next_state = REL_MAC;
                end
            end
            REL_MAC: begin
                if (!lock_s) begin
                    next_state = PLL_RST;
                    lock_lost  = 1'b1;
                end else begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = PLL_RST;
                    lock_lost  = 1'b1;
                end
            end
            default: next_state = PLL_RST;
        endcase
    end

    // State, timer, retry count and outputs registered from the state being entered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            phy_rst   <= 1'b1;
            mac_rst   <= 1'b1;
            sys_ready <= 1'b0;
            retry_cnt <= '0;
        end else begin
            state     <= next_state;
            timer     <= (next_state != state) ? '0 : timer + CNT_W'(1);
            pll_rst   <= (next_state == PLL_RST);
            phy_rst   <= (next_state inside {PLL_RST, WAIT_LOCK, STABLE});
            mac_rst   <= !(next_state inside {REL_MAC, RUN});
            sys_ready <= (next_state == RUN);
            if (timeout_hit && (retry_cnt != {RETRY_W{1'b1}})) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
        end
    end

`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
    // Saturating count of lock losses after the PHY reset was released.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
        end
    end
`else
    // Lock-loss flag has no consumer when the counter is not built.
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: tb/tb_eth_pll_reset_sequencer.sv
// Self-checking bench for eth_pll_reset_sequencer. A cycle-level reference
// model built from phase durations tracks the expected outputs every cycle.
module tb_eth_pll_reset_sequencer;

    localparam int PRC = 4;
    localparam int TO  = 20;
    localparam int ST  = 8;
    localparam int GAP = 5;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst, phy_rst, mac_rst, sys_ready;
    logic [2:0] seq_state;
    logic [3:0] retry_cnt;
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, the cycle the phase started, a 2-deep
    // lock delay line, and the two counters.
    int cyc = 0;
    int m_phase;
    int m_start;
    bit m_s1, m_s2;
    int m_retry;
    int m_loss;

    eth_pll_reset_sequencer #(
        .PLL_RST_CYCLES      (PRC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES       (ST),
        .SEQ_GAP_CYCLES      (GAP),
        .CNT_W               (20)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .phy_rst       (phy_rst),
        .mac_rst       (mac_rst),
        .sys_ready     (sys_ready),
        .seq_state     (seq_state),
        .retry_cnt     (retry_cnt)
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_start = cyc;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_retry = 0;
        m_loss  = 0;
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_start = cyc + 1;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step();
        bit lk;
        int e;
        lk = m_s2;
        e  = cyc - m_start;
        case (m_phase)
            0: if (e == PRC - 1) enter(1);
            1: begin
                if (lk) enter(2);
                else if (e == TO - 1) begin
                    if (m_retry < 15) m_retry++;
                    enter(0);
                end
            end
            2: begin
                if (!lk) enter(1);
                else if (e == ST - 1) enter(3);
            end
            default: begin
                if (!lk) begin
                    if (m_loss < 255) m_loss++;
                    enter(0);
                end else if (m_phase == 3 && e == GAP - 1) enter(4);
                else if (m_phase == 4) enter(5);
            end
        endcase
        m_s2 = m_s1;
        m_s1 = pll_locked;
        cyc++;
    endtask

    task automatic check_outputs();
        check("pll_rst", pll_rst, m_phase == 0);
        check("phy_rst", phy_rst, m_phase < 3);
        check("mac_rst", mac_rst, m_phase < 4);
        check("sys_ready", sys_ready, m_phase == 5);
        check("seq_state", seq_state, m_phase);
        check("retry_cnt", retry_cnt, m_retry);
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_phy_rst"}, phy_rst, 1);
        check({tag, "_mac_rst"}, mac_rst, 1);
        check({tag, "_sys_ready"}, sys_ready, 0);
        check({tag, "_seq_state"}, seq_state, 0);
        check({tag, "_retry_cnt"}, retry_cnt, 0);
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
        check({tag, "_lock_loss_cnt"}, lock_loss_cnt, 0);
`endif
    endtask

    task automatic cycle();
        @(posedge refclk);
        #1;
        model_step();
        check_outputs();
    endtask

    // Advance until the model sits in phase p with e cycles elapsed.
    task automatic run_until(input int p, input int e, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_phase == p && (cyc - m_start) == e) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $error("FAIL %s_timeout observed budget %0d expired expected phase %0d", tag, budget, p);
        end
    endtask

    initial begin
        int saved_retry;

        // Reset state.
        rst        = 1'b1;
        pll_locked = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(posedge refclk);
        #1;
        rst = 1'b0;

        // Nominal: lock rises 3 cycles after pll_rst falls.
        run_until(1, 0, 50, "nom_wait_lock");
        check("nom_pll_rst_low", pll_rst, 0);
        repeat (3) cycle();
        pll_locked = 1'b1;
        run_until(5, 0, 100, "nom_run");
        check("nom_sys_ready", sys_ready, 1);
        check("nom_state", seq_state, 5);
        repeat (4) cycle();

        // Lock loss in RUN.
        saved_retry = m_retry;
        pll_locked  = 1'b0;
        repeat (3) cycle();
        check("loss_pll_rst", pll_rst, 1);
        check("loss_phy_rst", phy_rst, 1);
        check("loss_mac_rst", mac_rst, 1);
        check("loss_sys_ready", sys_ready, 0);
        check("loss_retry", retry_cnt, saved_retry);
`ifdef ETH_PLL_LOCK_LOSS_CNT_EN
        check("loss_cnt_one", lock_loss_cnt, 1);
`endif

        // Coincident timeout and lock: lock_s rises at timer 19.
        run_until(1, TO - 3, 100, "coinc_wait");
        saved_retry = m_retry;
        pll_locked  = 1'b1;
        repeat (3) cycle();
        check("coinc_state", seq_state, 2);
        check("coinc_retry", retry_cnt, saved_retry);

        // One-cycle lock glitch seen at STABLE timer 5.
        run_until(2, 3, 100, "glitch_stable");
        pll_locked = 1'b0;
        cycle();
        pll_locked = 1'b1;
        repeat (2) cycle();
        check("glitch_state", seq_state, 1);
        check("glitch_phy_rst", phy_rst, 1);
        run_until(5, 0, 100, "glitch_run");

        // Asynchronous reset in REL_PHY, then full replay.
        pll_locked = 1'b0;
        run_until(1, 2, 100, "arst_relock");
        pll_locked = 1'b1;
        run_until(3, 2, 100, "arst_rel_phy");
        check("arst_pre_phy_rst", phy_rst, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("arst_immediate");
        model_reset();
        repeat (3) begin
            @(posedge refclk);
            #1;
            check_reset_values("arst_held");
        end
        rst = 1'b0;
        run_until(5, 0, 200, "arst_replay");
        check("arst_replay_ready", sys_ready, 1);

        // Timeouts with lock held low until retry_cnt saturates.
        pll_locked = 1'b0;
        repeat (17 * (PRC + TO) + 10) cycle();
        check("timeout_sat", retry_cnt, 15);

        // Randomized lock activity with mixed toggle rates.
        for (int blk = 0; blk < 6; blk++) begin
            int rate;
            rate = (blk % 2 == 0) ? 8 : 60;
            repeat (500) begin
                if ($urandom_range(0, rate - 1) == 0) pll_locked = ~pll_locked;
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
